serial_link_tx: RTL and testbench

Parametrised successor to the team's fixed 8-bit two-line serial transmitter. Serialises DATA_W-bit parallel words into framed bursts on a forwarded clock plus data line, MSB first. Adds a one-word holding buffer with a Send/Ready handshake, a configurable inter-frame idle gap, and an optional parity bit. Sits between a parallel producer and the team's two-line serial link.

---
 rtl/serial_link_pkg.sv | 21 ++
 rtl/serial_link_tx_if.sv | 18 +
 rtl/serial_link_hold_reg.sv | 35 +++
 rtl/serial_link_tx.sv | 164 ++++++++++++++++
 tb/tb_serial_link_tx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_link_pkg.sv
// Shared types for the serial link transmitter: FSM states, gap counter width, frame length helper.
// Optional PARITY_EN adds the PARITY state to the enum.
package serial_link_pkg;

    localparam int GAP_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PARITY_EN
        S_PARITY,
`endif
        S_GAP
    } state_t;

    function automatic int frame_len(input int data_w, input bit parity);
        return 1 + data_w + (parity ? 1 : 0);
    endfunction

endpackage

// File: rtl/serial_link_tx_if.sv
// Producer-side handshake plus the two-line serial outputs of serial_link_tx.
// master = producer/observer, slave = transmitter.
interface serial_link_tx_if #(
    parameter int DATA_W = 8
) ();

    logic              send;
    logic [DATA_W-1:0] pdin;
    logic              ready;
    logic              soclk;
    logic              sdout;
    logic              busy;
    logic              frame_done;

    modport master (output send, pdin, input ready, soclk, sdout, busy, frame_done);
    modport slave  (input send, pdin, output ready, soclk, sdout, busy, frame_done);

endinterface

// File: rtl/serial_link_hold_reg.sv
// One-entry word buffer between producer and shifter; load and take are never concurrent.
// Ready is the registered inverse of the valid flag, so it moves one cycle after load/take.
module serial_link_hold_reg #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_take,
    input  logic [DATA_W-1:0] i_dat,
    output logic [DATA_W-1:0] o_dat,
    output logic              o_vld,
    output logic              o_rdy
);

    logic              r_vld;
    logic [DATA_W-1:0] r_dat;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else if (i_load) begin
            r_vld <= 1'b1;
            r_dat <= i_dat;
        end else if (i_take) begin
            r_vld <= 1'b0;
        end
    end

    assign o_dat = r_dat;
    assign o_vld = r_vld;
    assign o_rdy = ~r_vld;

endmodule

// File: rtl/serial_link_tx.sv
// Framed MSB-first serialiser: start bit, DATA_W data bits, optional even parity (PARITY_EN), GAP_CYCLES low.
// Start bit follows the accepting edge; a second word waits in the hold register with Ready low.
module serial_link_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    serial_link_tx_if.slave bus
);

    localparam int                CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES);

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0]  r_bitcnt, w_bitcnt_nxt;
    logic [GAP_W-1:0]  r_gapcnt, w_gapcnt_nxt;
    logic              r_sdout, w_sdout_nxt;
    logic              r_done, w_done_nxt;
`ifdef PARITY_EN
    logic              r_par, w_par_nxt;
`endif

    logic              w_accept, w_load, w_take;
    logic              w_start, w_frame_end, w_next_word;
    logic [DATA_W-1:0] w_start_dat;
    logic [DATA_W-1:0] w_hold_dat;
    logic              w_hold_vld, w_hold_rdy;

    assign w_accept = bus.send && w_hold_rdy;
    assign w_load   = w_accept && (r_state != S_IDLE);

    serial_link_hold_reg #(.DATA_W(DATA_W)) u_hold (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (w_load),
        .i_take (w_take),
        .i_dat  (bus.pdin),
        .o_dat  (w_hold_dat),
        .o_vld  (w_hold_vld),
        .o_rdy  (w_hold_rdy)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_gapcnt_nxt = r_gapcnt;
        w_sdout_nxt  = 1'b0;
        w_done_nxt   = 1'b0;
        w_take       = 1'b0;
        w_start      = 1'b0;
        w_start_dat  = '0;
        w_frame_end  = 1'b0;
        w_next_word  = 1'b0;
`ifdef PARITY_EN
        w_par_nxt    = r_par;
`endif
        unique case (r_state)
            S_IDLE: begin
                // A word parked while the last gap ended takes priority over the bypass path
                if (w_hold_vld) begin
                    w_next_word = 1'b1;
                end else if (w_accept) begin
                    w_start     = 1'b1;
                    w_start_dat = bus.pdin;
                end
            end
            S_START: begin
                w_state_nxt  = S_DATA;
                w_bitcnt_nxt = '0;
                w_sdout_nxt  = r_shift[DATA_W-1];
                w_shift_nxt  = {r_shift[DATA_W-2:0], 1'b0};
            end
            S_DATA: begin
                if (r_bitcnt == LAST_BIT) begin
`ifdef PARITY_EN
                    w_state_nxt = S_PARITY;
                    w_sdout_nxt = r_par;
`else
                    w_frame_end = 1'b1;
`endif
                end else begin
                    w_bitcnt_nxt = r_bitcnt + 1'b1;
                    w_sdout_nxt  = r_shift[DATA_W-1];
                    w_shift_nxt  = {r_shift[DATA_W-2:0], 1'b0};
                end
            end
`ifdef PARITY_EN
            S_PARITY: w_frame_end = 1'b1;
`endif
            S_GAP: begin
                if (r_gapcnt == GAP_W'(1)) begin
                    w_next_word = 1'b1;
                end else begin
                    w_gapcnt_nxt = r_gapcnt - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_frame_end) begin
            w_done_nxt = 1'b1;
            if (GAP_CYCLES > 0) begin
                w_state_nxt  = S_GAP;
                w_gapcnt_nxt = GAP_LOAD;
            end else begin
                w_next_word = 1'b1;
            end
        end
        if (w_next_word) begin
            if (w_hold_vld) begin
                w_take      = 1'b1;
                w_start     = 1'b1;
                w_start_dat = w_hold_dat;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
        if (w_start) begin
            w_state_nxt = S_START;
            w_shift_nxt = w_start_dat;
            w_sdout_nxt = 1'b1;
`ifdef PARITY_EN
            w_par_nxt   = ^w_start_dat;
`endif
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_gapcnt <= '0;
            r_sdout  <= 1'b0;
            r_done   <= 1'b0;
`ifdef PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_shift  <= w_shift_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_gapcnt <= w_gapcnt_nxt;
            r_sdout  <= w_sdout_nxt;
            r_done   <= w_done_nxt;
`ifdef PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

    assign bus.ready      = w_hold_rdy;
    assign bus.soclk      = i_clk;
    assign bus.sdout      = r_sdout;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = r_done;

endmodule

// File: tb/tb_serial_link_tx.sv
// Three transmitter configurations (8/GAP1, 8/GAP0, 16/GAP3) driven by directed and random producers,
// each compared cycle by cycle with a frame-position reference model.
module tb_serial_link_tx;

    localparam int NI = 3;
`ifdef PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tb_send [NI];
    logic [31:0] tb_pdin [NI];
    int          W [NI] = '{8, 8, 16};
    int          G [NI] = '{1, 0, 3};
    int          n_checks = 0;
    int          n_errors = 0;

    // reference model: position inside the current frame+gap period and a one-word queue
    bit          m_busy [NI];
    int          m_idx  [NI];
    logic [31:0] m_word [NI];
    logic [31:0] m_buf  [NI];
    bit          m_bvld [NI];
    bit          m_done [NI];

    serial_link_tx_if #(.DATA_W(8))  if0 ();
    serial_link_tx_if #(.DATA_W(8))  if1 ();
    serial_link_tx_if #(.DATA_W(16)) if2 ();

    assign if0.send = tb_send[0];
    assign if0.pdin = tb_pdin[0][7:0];
    assign if1.send = tb_send[1];
    assign if1.pdin = tb_pdin[1][7:0];
    assign if2.send = tb_send[2];
    assign if2.pdin = tb_pdin[2][15:0];

    serial_link_tx #(.DATA_W(8),  .GAP_CYCLES(1)) u0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    serial_link_tx #(.DATA_W(8),  .GAP_CYCLES(0)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    serial_link_tx #(.DATA_W(16), .GAP_CYCLES(3)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2));

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void get_out(input int n, output logic sd, output logic bz,
                                    output logic dn, output logic rd);
        case (n)
            0:       begin sd = if0.sdout; bz = if0.busy; dn = if0.frame_done; rd = if0.ready; end
            1:       begin sd = if1.sdout; bz = if1.busy; dn = if1.frame_done; rd = if1.ready; end
            default: begin sd = if2.sdout; bz = if2.busy; dn = if2.frame_done; rd = if2.ready; end
        endcase
    endfunction

    function automatic logic exp_sd(input int n);
        int idx;
        idx = m_idx[n];
        if (!m_busy[n])                 return 1'b0;
        if (idx == 0)                   return 1'b1;
        if (idx <= W[n])                return m_word[n][W[n] - idx];
        if (PAR == 1 && idx == W[n] + 1) return ^m_word[n];
        return 1'b0;
    endfunction

    task automatic model_edge(input int n);
        int          f;
        bit          acc, busy0, end_p, start;
        logic [31:0] sw;
        f     = 1 + W[n] + PAR;
        acc   = tb_send[n] && !m_bvld[n];
        busy0 = m_busy[n];
        end_p = busy0 && (m_idx[n] == f + G[n] - 1);
        m_done[n] = busy0 && (m_idx[n] == f - 1);
        start = 1'b0;
        sw    = '0;
        if (!busy0) begin
            if (m_bvld[n]) begin
                start = 1'b1; sw = m_buf[n]; m_bvld[n] = 1'b0;
            end else if (acc) begin
                start = 1'b1; sw = tb_pdin[n];
            end
        end else begin
            if (end_p) begin
                if (m_bvld[n]) begin
                    start = 1'b1; sw = m_buf[n]; m_bvld[n] = 1'b0;
                end else begin
                    m_busy[n] = 1'b0;
                end
            end else begin
                m_idx[n]++;
            end
            if (acc) begin
                m_buf[n] = tb_pdin[n]; m_bvld[n] = 1'b1;
            end
        end
        if (start) begin
            m_busy[n] = 1'b1; m_idx[n] = 0; m_word[n] = sw;
        end
    endtask

    task automatic compare(input int n);
        logic sd, bz, dn, rd;
        get_out(n, sd, bz, dn, rd);
        check($sformatf("u%0d_sdout", n), 32'(sd), 32'(exp_sd(n)));
        check($sformatf("u%0d_busy", n),  32'(bz), 32'(m_busy[n]));
        check($sformatf("u%0d_done", n),  32'(dn), 32'(m_done[n]));
        check($sformatf("u%0d_ready", n), 32'(rd), 32'(!m_bvld[n]));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int n = 0; n < NI; n++) model_edge(n);
        #1;
        check("soclk_high", 32'(if0.soclk), 32'd1);
        @(negedge clk);
        for (int n = 0; n < NI; n++) compare(n);
        check("soclk_low", 32'(if0.soclk), 32'd0);
    endtask

    task automatic do_reset();
        logic sd, bz, dn, rd;
        rst = 1'b1;
        #1;
        for (int n = 0; n < NI; n++) begin
            get_out(n, sd, bz, dn, rd);
            check($sformatf("u%0d_rst_sdout", n), 32'(sd), 32'd0);
            check($sformatf("u%0d_rst_busy", n),  32'(bz), 32'd0);
            check($sformatf("u%0d_rst_ready", n), 32'(rd), 32'd1);
            check($sformatf("u%0d_rst_done", n),  32'(dn), 32'd0);
            m_busy[n] = 1'b0; m_idx[n] = 0; m_word[n] = '0;
            m_buf[n]  = '0;   m_bvld[n] = 1'b0; m_done[n] = 1'b0;
        end
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [8:0] fr;
        int         cnt, s2;
        logic [31:0] mask;
        for (int n = 0; n < NI; n++) begin
            tb_send[n] = 1'b0;
            tb_pdin[n] = '0;
        end
        do_reset();

        // 0xA5 on the 8-bit GAP=1 link
        fr = 9'b1_1010_0101;
        tb_send[0] = 1'b1; tb_pdin[0] = 32'hA5;
        for (int e = 0; e <= 11; e++) begin
            tick();
            if (e == 0) tb_send[0] = 1'b0;
            if (e <= 8) begin
                check("a5_bit", 32'(if0.sdout), 32'(fr[8-e]));
            end else begin
                check("a5_done", 32'(if0.frame_done), 32'(e == 9 + PAR));
                check("a5_busy", 32'(if0.busy), 32'(e < 10 + PAR));
                check("a5_tail_low", 32'(if0.sdout), 32'd0);
            end
        end

        // 0x07: odd number of ones, so a parity bit (when built) is 1
        fr = 9'b1_0000_0111;
        tb_send[0] = 1'b1; tb_pdin[0] = 32'h07;
        for (int e = 0; e <= 11; e++) begin
            tick();
            if (e == 0) tb_send[0] = 1'b0;
            if (e <= 8) check("p07_bit", 32'(if0.sdout), 32'(fr[8-e]));
            if (e == 9) check("p07_par", 32'(if0.sdout), 32'(PAR));
        end

        // back-to-back on the GAP=0 link, Send held; 0xFF offered while the buffer is full
        cnt = 0;
        tb_send[1] = 1'b1; tb_pdin[1] = 32'h3C;
        for (int e = 0; e <= 27; e++) begin
            tick();
            if (if1.frame_done) cnt++;
            if (e == 0) tb_pdin[1] = 32'hC3;
            if (e == 1) tb_pdin[1] = 32'hFF;
            if (e >= 1 && e < 9 + PAR) check("b2b_ready_low", 32'(if1.ready), 32'd0);
            if (e == 9 + PAR) begin
                check("b2b_restart", 32'(if1.sdout), 32'd1);
                check("b2b_done_at_restart", 32'(if1.frame_done), 32'd1);
                check("b2b_ready_back", 32'(if1.ready), 32'd1);
                tb_send[1] = 1'b0;
            end
        end
        check("b2b_frames", 32'(cnt), 32'd2);

        // reset in the middle of 0xF0 with 0x55 buffered, then a clean 0x81
        tb_send[0] = 1'b1; tb_pdin[0] = 32'hF0;
        tick();
        tb_pdin[0] = 32'h55;
        tick();
        tb_send[0] = 1'b0;
        tick(); tick(); tick();
        check("rst_pre_busy", 32'(if0.busy), 32'd1);
        check("rst_pre_ready", 32'(if0.ready), 32'd0);
        do_reset();
        fr = 9'b1_1000_0001;
        tb_send[0] = 1'b1; tb_pdin[0] = 32'h81;
        for (int e = 0; e <= 12; e++) begin
            tick();
            if (e == 0) tb_send[0] = 1'b0;
            if (e <= 8) check("r81_bit", 32'(if0.sdout), 32'(fr[8-e]));
        end

        // 16-bit GAP=3 link: 0x8001 then a queued 0x1234
        tb_send[2] = 1'b1; tb_pdin[2] = 32'h8001;
        tick();
        tb_pdin[2] = 32'h1234;
        tick();
        tb_send[2] = 1'b0;
        s2 = 17 + PAR + 3;
        for (int e = 2; e <= s2; e++) begin
            tick();
            if (e == 16) check("w16_lsb", 32'(if2.sdout), 32'd1);
            if (e >= 17 + PAR && e < s2) check("gap_low", 32'(if2.sdout), 32'd0);
            if (e == s2) check("gap_next_start", 32'(if2.sdout), 32'd1);
        end
        for (int e = 0; e < 24; e++) tick();

        // random producers with bursty phases and occasional asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < NI; n++) begin
                mask = (32'h1 << W[n]) - 32'h1;
                if (((c / 400) % 2) == 1) tb_send[n] = ($urandom_range(0, 4) != 0);
                else                      tb_send[n] = ($urandom_range(0, 3) == 0);
                tb_pdin[n] = $urandom & mask;
            end
            tick();
            if ($urandom_range(0, 599) == 0) do_reset();
        end
        for (int n = 0; n < NI; n++) tb_send[n] = 1'b0;
        for (int e = 0; e < 30; e++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
